// File: rtl/add_unit.sv
// -----------------------------------------------------------------------------
// add_unit
//   Ripple-carry adder with registered outputs. WIDTH full-adder cells are
//   chained from bit 0 upward; the sum, carry-out and signed overflow are
//   captured on the rising edge of clk whenever in_valid is high, and held
//   otherwise. With WIDTH = 1 this is a registered single-bit full adder.
//
// Parameters
//   WIDTH      operand / sum width in bits (1..64)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears all outputs)
//   in_valid   a, b, c_i are valid this cycle
//   a, b       operands (unsigned; two's complement view used for ovf)
//   c_i        carry into bit 0
//   s          registered sum
//   c_o        registered carry out of bit WIDTH-1
//   ovf        registered signed overflow (carry into MSB ^ carry out of MSB)
//   out_valid  s, c_o, ovf hold a result captured on the previous edge
// -----------------------------------------------------------------------------
module add_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  output logic [WIDTH-1:0] s,
  output logic             c_o,
  output logic             ovf,
  output logic             out_valid
);

  // k[i] is the carry into cell i; k[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  always_comb begin
    k     = '0;
    sum_d = '0;
    k[0]  = c_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i] = a[i] ^ b[i] ^ k[i];
      k[i+1]   = (a[i] & b[i]) | (a[i] & k[i]) | (b[i] & k[i]);
    end
    // For WIDTH = 1 the carry into the MSB is c_i itself.
    ovf_d = k[WIDTH] ^ k[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      c_o       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s   <= sum_d;
        c_o <= k[WIDTH];
        ovf <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_add_unit.sv
// -----------------------------------------------------------------------------
// tb_add_unit
//   Directed checks of add_unit at WIDTH = 1 (exhaustive truth table, reset,
//   hold) and WIDTH = 8 (carry propagation, signed overflow, gaps), followed
//   by a short randomized run against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_add_unit;

  logic clk;
  logic rst_n;

  // WIDTH = 1 instance
  logic in_valid1, a1, b1, ci1;
  logic s1, co1, ovf1, ov1;

  // WIDTH = 8 instance
  logic       in_valid8, ci8;
  logic [7:0] a8, b8, s8;
  logic       co8, ovf8, ov8;

  int n_checks;
  int n_fail;

  add_unit #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .c_i       (ci1),
    .s         (s1),
    .c_o       (co1),
    .ovf       (ovf1),
    .out_valid (ov1)
  );

  add_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .c_i       (ci8),
    .s         (s8),
    .c_o       (co8),
    .ovf       (ovf8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed WIDTH = 1 truth table, indexed by {a, b, c_i}.
  logic [1:0] exp_cs1  [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic       exp_ovf1 [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Hand-computed WIDTH = 8 vectors: a, b, c_i, s, c_o, ovf.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec8_t;

  vec8_t vecs [8] = '{
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0},
    '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0},
    '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1}
  };

  initial begin
    logic [8:0] full;
    logic [7:0] exp_s;
    logic       exp_co, exp_ovf, v;
    logic [2:0] abc;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    in_valid8 = 1'b0; a8 = '0;   b8 = '0;   ci8 = 1'b0;

    // Reset state
    tick();
    check("rst_s1",  {63'd0, s1},   64'd0);
    check("rst_co1", {63'd0, co1},  64'd0);
    check("rst_ov1", {63'd0, ov1},  64'd0);
    check("rst_s8",  {56'd0, s8},   64'd0);
    check("rst_ov8", {63'd0, ov8},  64'd0);
    #2 rst_n = 1'b1;

    // First edge after release captures
    abc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      {a1, b1, ci1} = abc;
      in_valid1 = 1'b1;
      tick();
      check($sformatf("tt_cs_%0d", i),  {62'd0, co1, s1}, {62'd0, exp_cs1[i]});
      check($sformatf("tt_ovf_%0d", i), {63'd0, ovf1},     {63'd0, exp_ovf1[i]});
      check($sformatf("tt_ov_%0d", i),  {63'd0, ov1},      64'd1);
    end

    // Asynchronous reset mid-cycle while holding the 1+1+1 result
    in_valid1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_s1",   {63'd0, s1},   64'd0);
    check("arst_co1",  {63'd0, co1},  64'd0);
    check("arst_ovf1", {63'd0, ovf1}, 64'd0);
    check("arst_ov1",  {63'd0, ov1},  64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_ov1_a", {63'd0, ov1}, 64'd0);
    tick();
    check("post_rst_ov1_b", {63'd0, ov1}, 64'd0);

    // Reset discards a result in flight
    {a1, b1, ci1} = 3'b111;
    in_valid1 = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    check("inflight_ov1", {63'd0, ov1},     64'd0);
    check("inflight_cs1", {62'd0, co1, s1}, 64'd0);
    rst_n = 1'b1;

    // Hold behaviour
    {a1, b1, ci1} = 3'b100;
    in_valid1 = 1'b1;
    tick();
    check("cap_cs1", {62'd0, co1, s1}, 64'b01);
    check("cap_ov1", {63'd0, ov1},     64'd1);
    {a1, b1, ci1} = 3'b111;
    in_valid1 = 1'b0;
    tick();
    check("hold_cs1", {62'd0, co1, s1}, 64'b01);
    check("hold_ov1", {63'd0, ov1},     64'd0);
    tick();
    check("hold2_cs1", {62'd0, co1, s1}, 64'b01);

    // WIDTH = 8 directed vectors, back to back
    for (int i = 0; i < 8; i++) begin
      a8 = vecs[i].a; b8 = vecs[i].b; ci8 = vecs[i].ci;
      in_valid8 = 1'b1;
      tick();
      check($sformatf("w8_s_%0d", i),   {56'd0, s8},   {56'd0, vecs[i].s});
      check($sformatf("w8_co_%0d", i),  {63'd0, co8},  {63'd0, vecs[i].co});
      check($sformatf("w8_ovf_%0d", i), {63'd0, ovf8}, {63'd0, vecs[i].ovf});
      check($sformatf("w8_ov_%0d", i),  {63'd0, ov8},  64'd1);
    end

    // Gap: last result (0x40+0x40) holds
    in_valid8 = 1'b0;
    a8 = 8'h01; b8 = 8'h01; ci8 = 1'b1;
    tick();
    check("w8_gap_s",   {56'd0, s8},   64'h80);
    check("w8_gap_ovf", {63'd0, ovf8}, 64'd1);
    check("w8_gap_ov",  {63'd0, ov8},  64'd0);

    // Randomized run with gaps against a + b + c_i
    exp_s = s8; exp_co = co8; exp_ovf = ovf8;
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      ci8 = 1'($urandom_range(0, 1));
      in_valid8 = v;
      if (v) begin
        full    = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
        exp_s   = full[7:0];
        exp_co  = full[8];
        exp_ovf = (a8[7] == b8[7]) && (full[7] != a8[7]);
      end
      tick();
      check($sformatf("rnd_ov_%0d", i),  {63'd0, ov8},               {63'd0, v});
      check($sformatf("rnd_res_%0d", i), {54'd0, ovf8, co8, s8},     {54'd0, exp_ovf, exp_co, exp_s});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
